// File: rtl/sub16sat_ramp_pkg.sv
// Shared blitter definitions for the saturating down-ramp generator.
// Holds the ramp state encoding, clamp limits and sign-extension helpers
// used by both the ramp controller and its combinational step core.
package sub16sat_ramp_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int WIDE_W = DATA_W + 2;
  localparam int LOWX_W = BYTE_W + 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ramp_state_e;

  localparam logic [DATA_W-1:0] SAT_LO  = 16'h0000;
  localparam logic [DATA_W-1:0] SAT_HI  = 16'hFFFF;
  localparam logic [BYTE_W-1:0] SAT_LO8 = 8'h00;
  localparam logic [BYTE_W-1:0] SAT_HI8 = 8'hFF;

  // Sign-extend a 16-bit step to the widened subtract width.
  function automatic logic [WIDE_W-1:0] sext_wide(input logic [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  // Sign-extend the low step byte to the widened byte-lane width.
  function automatic logic [LOWX_W-1:0] sext_byte(input logic [BYTE_W-1:0] v);
    return {{2{v[BYTE_W-1]}}, v};
  endfunction

endpackage

// File: rtl/sub16sat_core.sv
// Combinational next() for the down-ramp: acc - step with optional
// clamping, independent low byte (eightbit) and high-nibble borrow inhibit.
// The clamp flag is high whenever the returned value came from a limit.
module sub16sat_core
  import sub16sat_ramp_pkg::*;
(
  input  logic [15:0] acc,
  input  logic [15:0] step,
  input  logic        sat,
  input  logic        eightbit,
  input  logic        hicinh,
  output logic [15:0] result,
  output logic        clamp
);

  logic [WIDE_W-1:0] wide_s;
  logic [LOWX_W-1:0] low_s;
  logic [7:0]        hi_byte_s;
  logic [3:0]        hi_nib_s;

  // Full-width difference keeps the sign and overflow bits for clamping.
  assign wide_s    = {2'b00, acc} - sext_wide(step);
  // Byte-lane difference for the independent low byte.
  assign low_s     = {2'b00, acc[7:0]} - sext_byte(step[7:0]);
  // High byte and high nibble never see a borrow from below.
  assign hi_byte_s = acc[15:8] - step[15:8];
  assign hi_nib_s  = acc[15:12] - step[15:12];

  // Select the lane arrangement and apply clamping.
  always_comb begin
    result = wide_s[15:0];
    clamp  = 1'b0;
    if (eightbit) begin
      if (sat && low_s[LOWX_W-1]) begin
        result = {hi_byte_s, SAT_LO8};
        clamp  = 1'b1;
      end else if (sat && low_s[BYTE_W]) begin
        result = {hi_byte_s, SAT_HI8};
        clamp  = 1'b1;
      end else begin
        result = {hi_byte_s, low_s[7:0]};
      end
    end else if (sat) begin
      if (wide_s[WIDE_W-1]) begin
        result = SAT_LO;
        clamp  = 1'b1;
      end else if (wide_s[DATA_W]) begin
        result = SAT_HI;
        clamp  = 1'b1;
      end else begin
        result = wide_s[15:0];
      end
    end else if (hicinh) begin
      result = {hi_nib_s, wide_s[11:0]};
    end else begin
      result = wide_s[15:0];
    end
  end

endmodule

// File: rtl/sub16sat_ramp.sv
// Saturating down-ramp generator for the blitter datapath.
// Loads a start value on a start pulse in IDLE, then presents count
// results on a valid/ready interface, each one step below the last.
// Optional build macro SUB16SAT_RAMP_SATFLAG_EN adds the r_sat and
// sat_seen clamp-status outputs.
module sub16sat_ramp
  import sub16sat_ramp_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   init,
  input  logic [15:0]   step,
  input  logic [CW-1:0] count,
  input  logic          sat,
  input  logic          eightbit,
  input  logic          hicinh,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   r,
  output logic          busy,
  output logic          done
`ifdef SUB16SAT_RAMP_SATFLAG_EN
  ,
  output logic          r_sat,
  output logic          sat_seen
`endif
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  ramp_state_e   state_r, state_nxt_s;
  logic [15:0]   acc_r, acc_nxt_s;
  logic [CW-1:0] rem_r, rem_nxt_s;
  logic [15:0]   step_r, step_nxt_s;
  logic          sat_r, sat_nxt_s;
  logic          eightbit_r, eightbit_nxt_s;
  logic          hicinh_r, hicinh_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          fire_s;
  logic          load_s;
  logic [15:0]   next_acc_s;
  logic          clamp_s;

  sub16sat_core u_core (
    .acc      (acc_r),
    .step     (step_r),
    .sat      (sat_r),
    .eightbit (eightbit_r),
    .hicinh   (hicinh_r),
    .result   (next_acc_s),
    .clamp    (clamp_s)
  );

  // A result is consumed only while it is being presented.
  assign fire_s = valid_r & out_ready;

  // Next-state, counter and handshake decisions.
  always_comb begin
    state_nxt_s    = state_r;
    acc_nxt_s      = acc_r;
    rem_nxt_s      = rem_r;
    step_nxt_s     = step_r;
    sat_nxt_s      = sat_r;
    eightbit_nxt_s = eightbit_r;
    hicinh_nxt_s   = hicinh_r;
    valid_nxt_s    = valid_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    load_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s         = 1'b1;
          acc_nxt_s      = init;
          step_nxt_s     = step;
          sat_nxt_s      = sat;
          eightbit_nxt_s = eightbit;
          hicinh_nxt_s   = hicinh;
          rem_nxt_s      = count;
          if (count != CNT_ZERO) begin
            state_nxt_s = RUN;
            valid_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (fire_s) begin
          acc_nxt_s = next_acc_s;
          rem_nxt_s = rem_r - CNT_ONE;
          if (rem_r == CNT_ONE) begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, accumulator, counter and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      acc_r      <= 16'h0000;
      rem_r      <= CNT_ZERO;
      step_r     <= 16'h0000;
      sat_r      <= 1'b0;
      eightbit_r <= 1'b0;
      hicinh_r   <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      acc_r      <= acc_nxt_s;
      rem_r      <= rem_nxt_s;
      step_r     <= step_nxt_s;
      sat_r      <= sat_nxt_s;
      eightbit_r <= eightbit_nxt_s;
      hicinh_r   <= hicinh_nxt_s;
      valid_r    <= valid_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign out_valid = valid_r;
  assign r         = acc_r;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef SUB16SAT_RAMP_SATFLAG_EN
  logic r_sat_r;
  logic sat_seen_r;

  // Clamp status travels with each accepted value; sticky flag per ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_r    <= 1'b0;
      sat_seen_r <= 1'b0;
    end else if (load_s) begin
      r_sat_r    <= 1'b0;
      sat_seen_r <= 1'b0;
    end else if (fire_s) begin
      r_sat_r    <= clamp_s;
      sat_seen_r <= sat_seen_r | clamp_s;
    end else begin
      r_sat_r    <= r_sat_r;
      sat_seen_r <= sat_seen_r;
    end
  end

  assign r_sat    = r_sat_r;
  assign sat_seen = sat_seen_r;
`else
  logic unused_flag_s;
  assign unused_flag_s = clamp_s | load_s;
`endif

endmodule

// File: tb/tb_sub16sat_ramp.sv
// Scoreboard bench for sub16sat_ramp: stimulus pushes hand-computed ramp
// values into a queue, a monitor pops and compares on every accepted output.
module tb_sub16sat_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] init;
  logic [15:0] step;
  logic [9:0]  count;
  logic        sat;
  logic        eightbit;
  logic        hicinh;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        busy;
  logic        done;
`ifdef SUB16SAT_RAMP_SATFLAG_EN
  logic        r_sat;
  logic        sat_seen;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] prev_r = 16'h0000;
  bit prev_stall = 1'b0;

  sub16sat_ramp #(.CW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .init      (init),
    .step      (step),
    .count     (count),
    .sat       (sat),
    .eightbit  (eightbit),
    .hicinh    (hicinh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy),
    .done      (done)
`ifdef SUB16SAT_RAMP_SATFLAG_EN
    ,
    .r_sat     (r_sat),
    .sat_seen  (sat_seen)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare every accepted output against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall)
        chk("stall_hold", {16'h0, r}, {16'h0, prev_r});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("r_extra_output", {16'h0, r}, 32'hFFFF_FFFF);
        else
          chk("r_value", {16'h0, r}, {16'h0, exp_q.pop_front()});
        last_acc_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = r;
    end
  end

  task automatic push_exp(input int n, input logic [15:0] a, b, c, d, e);
    logic [15:0] v [5];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  // Issue one start pulse; scramble inputs afterwards to prove they were latched.
  task automatic start_ramp(input logic [15:0] i0, input logic [15:0] s0, input logic [9:0] c0,
                            input logic sa, input logic eb, input logic hc);
    @(posedge clk); #1;
    init = i0; step = s0; count = c0; sat = sa; eightbit = eb; hicinh = hc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    init = 16'hDEAD; step = 16'h1357; count = 10'd9; sat = ~sa; eightbit = ~eb; hicinh = ~hc;
    if (c0 != 10'd0) begin
      @(negedge clk);
      chk("first_valid", {31'h0, out_valid}, 32'h1);
      chk("busy_in_run", {31'h0, busy}, 32'h1);
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, {31'h0, seen}, 32'h1);
    if (seen) begin
      chk({nm, "_done_latency"}, cyc, last_acc_cyc + 1);
      chk({nm, "_valid_low"}, {31'h0, out_valid}, 32'h0);
      chk({nm, "_queue_empty"}, exp_q.size(), 32'h0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, {31'h0, done}, 32'h0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; init = 16'h0; step = 16'h0; count = 10'd0;
    sat = 1'b0; eightbit = 1'b0; hicinh = 1'b0; out_ready = 1'b1;
    // Reset state
    @(posedge clk); #1;
    init = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_r", {16'h0, r}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain clamped ramp down to zero
    push_exp(5, 16'h0100, 16'h00C0, 16'h0080, 16'h0040, 16'h0000);
    start_ramp(16'h0100, 16'h0040, 10'd5, 1'b1, 1'b0, 1'b0);
    wait_done("basic");

    // Underflow clamped vs wrapped
    push_exp(3, 16'h0030, 16'h0010, 16'h0000, 16'h0, 16'h0);
    start_ramp(16'h0030, 16'h0020, 10'd3, 1'b1, 1'b0, 1'b0);
    wait_done("under_sat");
    push_exp(3, 16'h0030, 16'h0010, 16'hFFF0, 16'h0, 16'h0);
    start_ramp(16'h0030, 16'h0020, 10'd3, 1'b0, 1'b0, 1'b0);
    wait_done("under_wrap");

    // Negative step overflows and clamps high
    push_exp(2, 16'hFFF0, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    start_ramp(16'hFFF0, 16'hFFE0, 10'd2, 1'b1, 1'b0, 1'b0);
    wait_done("over_sat");

    // Eightbit: low byte clamps low, high byte subtracts independently
    push_exp(2, 16'h1205, 16'h1100, 16'h0, 16'h0, 16'h0);
    start_ramp(16'h1205, 16'h0108, 10'd2, 1'b1, 1'b1, 1'b0);
    wait_done("eb_lo_clamp");

    // Eightbit: low byte clamps high using sign of step[7:0]
    push_exp(2, 16'h00F0, 16'h00FF, 16'h0, 16'h0, 16'h0);
    start_ramp(16'h00F0, 16'h00E0, 10'd2, 1'b1, 1'b1, 1'b0);
    wait_done("eb_hi_clamp");

    // Eightbit without sat: no borrow from low byte into high byte
    push_exp(2, 16'h0003, 16'hFFFE, 16'h0, 16'h0, 16'h0);
    start_ramp(16'h0003, 16'h0105, 10'd2, 1'b0, 1'b1, 1'b0);
    wait_done("eb_wrap");

    // High-nibble borrow inhibit, and ignored when sat=1
    push_exp(2, 16'h1005, 16'h1FF5, 16'h0, 16'h0, 16'h0);
    start_ramp(16'h1005, 16'h0010, 10'd2, 1'b0, 1'b0, 1'b1);
    wait_done("hicinh");
    push_exp(2, 16'h1005, 16'h0FF5, 16'h0, 16'h0, 16'h0);
    start_ramp(16'h1005, 16'h0010, 10'd2, 1'b1, 1'b0, 1'b1);
    wait_done("hicinh_ign");

    // Back-pressure 1,0,0,1 with a start pulse during the stall
    push_exp(4, 16'h0100, 16'h00F0, 16'h00E0, 16'h00D0, 16'h0);
    start_ramp(16'h0100, 16'h0010, 10'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; out_ready = 1'b0;
    @(posedge clk); #1; out_ready = 1'b0;
    init = 16'hAAAA; step = 16'h0001; count = 10'd7; start = 1'b1;
    @(posedge clk); #1; out_ready = 1'b1; start = 1'b0;
    wait_done("stall");

    // count==0: done next cycle, no output
    start_ramp(16'h4444, 16'h0001, 10'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt0_done", {31'h0, done}, 32'h1);
    chk("cnt0_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("cnt0_done_pulse", {31'h0, done}, 32'h0);
    chk("cnt0_valid2", {31'h0, out_valid}, 32'h0);

    // Reset mid-ramp abandons the ramp without done
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h8000 - 16'(i));
    start_ramp(16'h8000, 16'h0001, 10'd10, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_r", {16'h0, r}, 32'h0);
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || out_valid) dn++;
    end
    chk("mid_rst_quiet", dn, 32'h0);

    chk("final_queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
